// File: rtl/bus_addr_dec_seq.sv
// Sequential bus address decoder and access tracker: one active-low chip-select per access,
// one-cycle master ready, bus error on unmapped index or (with BUS_DEC_WATCHDOG_EN) ready timeout.
module bus_addr_dec_seq #(
  parameter int ADDR_W  = 30,
  parameter int SLAVE_N = 8,
  parameter int IDX_W   = 3,
  parameter int TO_W    = 8,
  parameter int TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               mAs_,
  input  logic [ADDR_W-1:0]  mAddr,
  input  logic [SLAVE_N-1:0] sRdy_,
  output logic [SLAVE_N-1:0] sCS_,
  output logic [IDX_W-1:0]   selIdx,
  output logic               mRdy_,
  output logic               busErr,
  output logic               busy
);

  typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_ERROR} state_t;

  state_t             state;
  logic [IDX_W-1:0]   req_idx;
  logic               req_mapped;
  logic [SLAVE_N-1:0] req_cs;
  logic               sel_rdy;
  logic               wd_expire;
  logic               unused_addr;

  if (SLAVE_N < 1 || longint'(SLAVE_N) > (longint'(1) << IDX_W)) begin : g_bad_slave_n
    $error("bus_addr_dec_seq: SLAVE_N must be 1..2**IDX_W");
  end
  if (TIMEOUT < 1 || longint'(TIMEOUT) >= (longint'(1) << TO_W)) begin : g_bad_timeout
    $error("bus_addr_dec_seq: TIMEOUT must be 1..2**TO_W-1");
  end
  if (ADDR_W <= IDX_W) begin : g_bad_addr_w
    $error("bus_addr_dec_seq: ADDR_W must exceed IDX_W");
  end

  assign req_idx     = mAddr[ADDR_W-1 -: IDX_W];
  assign req_mapped  = int'(req_idx) < SLAVE_N;
  assign sel_rdy     = ~sRdy_[selIdx];
  // Only the index field is decoded; the word offset belongs to the slave.
  assign unused_addr = ^mAddr[ADDR_W-IDX_W-1:0];

  always_comb begin
    req_cs = '1;
    for (int unsigned i = 0; i < SLAVE_N; i++) begin
      if (req_idx == IDX_W'(i)) req_cs[i] = 1'b0;
    end
  end

`ifdef BUS_DEC_WATCHDOG_EN
  logic [TO_W-1:0] wd_cnt;

  // wd_cnt == TIMEOUT-1 on a non-ready edge means this edge brings the count to TIMEOUT.
  assign wd_expire = (wd_cnt == TO_W'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wd_cnt <= '0;
    end else if (state == ST_IDLE) begin
      wd_cnt <= '0;
    end else if (state == ST_ACCESS && !sel_rdy) begin
      wd_cnt <= wd_cnt + 1'b1;
    end
  end
`else
  assign wd_expire = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= ST_IDLE;
      sCS_   <= '1;
      selIdx <= '0;
      mRdy_  <= 1'b1;
      busErr <= 1'b0;
      busy   <= 1'b0;
    end else begin
      mRdy_  <= 1'b1;
      busErr <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (!mAs_) begin
            selIdx <= req_idx;
            busy   <= 1'b1;
            if (req_mapped) begin
              sCS_  <= req_cs;
              state <= ST_ACCESS;
            end else begin
              state <= ST_ERROR;
            end
          end
        end
        ST_ACCESS: begin
          // Ready is tested first so it wins over a coincident timeout.
          if (sel_rdy) begin
            mRdy_ <= 1'b0;
            sCS_  <= '1;
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else if (wd_expire) begin
            sCS_  <= '1;
            state <= ST_ERROR;
          end
        end
        ST_ERROR: begin
          mRdy_  <= 1'b0;
          busErr <= 1'b1;
          sCS_   <= '1;
          busy   <= 1'b0;
          state  <= ST_IDLE;
        end
        default: begin
          sCS_  <= '1;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_addr_dec_seq.sv
// Self-checking bench for bus_addr_dec_seq: an 8-slave and a 6-slave instance share the stimulus and
// are compared every cycle against a transaction-level model; directed cases pin the model with literals.
module tb_bus_addr_dec_seq;
  localparam int TMO = 4;
`ifdef BUS_DEC_WATCHDOG_EN
  localparam bit WD = 1'b1;
`else
  localparam bit WD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mas = 1'b1;
  logic [29:0] addr = '0;
  logic [7:0]  srdy = '1;

  logic [7:0] cs8;  logic [2:0] sel8; logic mrdy8, err8, busy8;
  logic [5:0] cs6;  logic [2:0] sel6; logic mrdy6, err6, busy6;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  bus_addr_dec_seq #(.ADDR_W(30), .SLAVE_N(8), .IDX_W(3), .TO_W(8), .TIMEOUT(TMO)) u_dut8 (
    .clk(clk), .reset(reset), .mAs_(mas), .mAddr(addr), .sRdy_(srdy),
    .sCS_(cs8), .selIdx(sel8), .mRdy_(mrdy8), .busErr(err8), .busy(busy8));

  bus_addr_dec_seq #(.ADDR_W(30), .SLAVE_N(6), .IDX_W(3), .TO_W(8), .TIMEOUT(TMO)) u_dut6 (
    .clk(clk), .reset(reset), .mAs_(mas), .mAddr(addr), .sRdy_(srdy[5:0]),
    .sCS_(cs6), .selIdx(sel6), .mRdy_(mrdy6), .busErr(err6), .busy(busy6));

  // Model: an access is either in flight on a slave, or an error reply is owed for the next cycle.
  typedef struct {
    bit          active;
    bit          err_due;
    int unsigned idx;
    int unsigned waited;
    bit          rdy_p;
    bit          err_p;
  } mdl_t;

  mdl_t m8, m6;

  function automatic mdl_t mdl_zero();
    mdl_t z;
    z.active = 0; z.err_due = 0; z.idx = 0; z.waited = 0; z.rdy_p = 0; z.err_p = 0;
    return z;
  endfunction

  function automatic mdl_t mdl_step(mdl_t m, int unsigned ns, logic as_n, logic [29:0] a, logic [7:0] rdy);
    mdl_t n = m;
    n.rdy_p = 0;
    n.err_p = 0;
    if (m.err_due) begin
      n.err_due = 0; n.rdy_p = 1; n.err_p = 1;
    end else if (m.active) begin
      if (rdy[m.idx] == 1'b0) begin
        n.active = 0; n.rdy_p = 1;
      end else begin
        n.waited = m.waited + 1;
        if (WD && n.waited == TMO) begin
          n.active = 0; n.err_due = 1;
        end
      end
    end else if (as_n == 1'b0) begin
      n.idx = int'(a[29:27]);
      n.waited = 0;
      if (n.idx < ns) n.active = 1;
      else n.err_due = 1;
    end
    return n;
  endfunction

  function automatic logic [7:0] mdl_cs(mdl_t m);
    logic [7:0] c = '1;
    if (m.active) c[m.idx] = 1'b0;
    return c;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m8 <= mdl_zero();
      m6 <= mdl_zero();
    end else begin
      m8 <= mdl_step(m8, 8, mas, addr, srdy);
      m6 <= mdl_step(m6, 6, mas, addr, srdy);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      logic [7:0] e8, e6;
      e8 = mdl_cs(m8);
      e6 = mdl_cs(m6);
      chk("cs8",    32'(cs8),    32'(e8));
      chk("sel8",   32'(sel8),   m8.idx);
      chk("mrdy8",  32'(mrdy8),  32'(!m8.rdy_p));
      chk("err8",   32'(err8),   32'(m8.err_p));
      chk("busy8",  32'(busy8),  32'(m8.active || m8.err_due));
      chk("cold8",  32'($countones(~cs8) <= 1), 32'd1);
      chk("cs6",    32'(cs6),    32'(e6[5:0]));
      chk("sel6",   32'(sel6),   m6.idx);
      chk("mrdy6",  32'(mrdy6),  32'(!m6.rdy_p));
      chk("err6",   32'(err6),   32'(m6.err_p));
      chk("busy6",  32'(busy6),  32'(m6.active || m6.err_due));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [2:0] idx);
    mas  = 1'b0;
    addr = {idx, 27'($urandom)};
    tick();
    mas  = 1'b1;
  endtask

  initial begin
    #400000;
    errors++;
    $display("FAIL sim_timeout: got no finish expected finish by %0t", $time);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "simulation time bound exceeded");
  end

  initial begin
    bit ok;
    tick(); tick();
    reset = 1'b0;
    chk("rst_cs",   32'(cs8),   32'hFF);
    chk("rst_mrdy", 32'(mrdy8), 32'd1);
    chk("rst_err",  32'(err8),  32'd0);
    chk("rst_sel",  32'(sel8),  32'd0);
    chk("rst_busy", 32'(busy8), 32'd0);
    tick();

    // Slave 5, ready sampled on the third edge after the request.
    start(3'd5);
    chk("s5_cs_e0", 32'(cs8), 32'hDF);
    chk("s5_busy",  32'(busy8), 32'd1);
    tick();  chk("s5_cs_e1", 32'(cs8), 32'hDF);
    tick();  chk("s5_cs_e2", 32'(cs8), 32'hDF);
    srdy[5] = 1'b0;
    tick();
    chk("s5_mrdy", 32'(mrdy8), 32'd0);
    chk("s5_err",  32'(err8),  32'd0);
    chk("s5_sel",  32'(sel8),  32'd5);
    chk("s5_cs_e3", 32'(cs8), 32'hFF);
    srdy = '1;
    tick();  chk("s5_mrdy_end", 32'(mrdy8), 32'd1);

    // Index 7 is unmapped on the 6-slave instance.
    start(3'd7);
    srdy = 8'h7F;
    chk("u7_cs_e0",  32'(cs6),   32'h3F);
    chk("u7_mrdy_e0", 32'(mrdy6), 32'd1);
    chk("u7_busy",   32'(busy6), 32'd1);
    tick();
    srdy = '1;
    chk("u7_mrdy", 32'(mrdy6), 32'd0);
    chk("u7_err",  32'(err6),  32'd1);
    chk("u7_cs_e1", 32'(cs6),  32'h3F);
    tick();
    chk("u7_mrdy_end", 32'(mrdy6), 32'd1);
    chk("u7_err_end",  32'(err6),  32'd0);
    tick();

`ifdef BUS_DEC_WATCHDOG_EN
    start(3'd1);
    chk("wd_cs_e0", 32'(cs8), 32'hFD);
    tick();  chk("wd_cs_e1", 32'(cs8), 32'hFD);
    tick();  chk("wd_cs_e2", 32'(cs8), 32'hFD);
    tick();  chk("wd_cs_e3", 32'(cs8), 32'hFD);
    tick();
    chk("wd_cs_e4",   32'(cs8),   32'hFF);
    chk("wd_busy_e4", 32'(busy8), 32'd1);
    chk("wd_mrdy_e4", 32'(mrdy8), 32'd1);
    tick();
    chk("wd_mrdy", 32'(mrdy8), 32'd0);
    chk("wd_err",  32'(err8),  32'd1);
    tick();
    chk("wd_idle", 32'(busy8), 32'd0);
    start(3'd1);
    tick(); tick(); tick();
    srdy = 8'hFD;
    tick();
    chk("wd_race_mrdy", 32'(mrdy8), 32'd0);
    chk("wd_race_err",  32'(err8),  32'd0);
    srdy = '1;
    tick();
`else
    start(3'd0);
    ok = 1'b1;
    repeat (1000) begin
      tick();
      if (cs8 !== 8'hFE || err8 !== 1'b0 || mrdy8 !== 1'b1) ok = 1'b0;
    end
    chk("nowd_hold", 32'(ok), 32'd1);
    srdy = 8'hFE;
    tick();
    chk("nowd_mrdy", 32'(mrdy8), 32'd0);
    chk("nowd_err",  32'(err8),  32'd0);
    srdy = '1;
    tick();
`endif

    // Back-to-back with strobe held low.
    srdy = 8'h00;
    mas  = 1'b0;
    addr = {3'd0, 27'h123};
    tick();  chk("b2b_cs0", 32'(cs8), 32'hFE);
    tick();  chk("b2b_mrdy0", 32'(mrdy8), 32'd0);
    addr = {3'd3, 27'h456};
    tick();
    chk("b2b_cs3",  32'(cs8),  32'hF7);
    chk("b2b_sel3", 32'(sel8), 32'd3);
    tick();  chk("b2b_mrdy3", 32'(mrdy8), 32'd0);
    mas  = 1'b1;
    srdy = '1;
    tick(); tick();

    // Asynchronous reset in the middle of an access.
    start(3'd2);
    tick();
    #3;
    reset = 1'b1;
    #1;
    chk("arst_cs",   32'(cs8),   32'hFF);
    chk("arst_busy", 32'(busy8), 32'd0);
    chk("arst_mrdy", 32'(mrdy8), 32'd1);
    chk("arst_sel",  32'(sel8),  32'd0);
    tick();
    reset = 1'b0;
    repeat (3) begin
      tick();
      chk("arst_nopulse", 32'(mrdy8), 32'd1);
    end

    repeat (3000) begin
      mas  = ($urandom_range(0, 2) == 0);
      addr = 30'($urandom);
      for (int i = 0; i < 8; i++) srdy[i] = ($urandom_range(0, 2) != 0);
      tick();
    end
    mas  = 1'b1;
    srdy = '1;
    repeat (6) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
